uart_rx_buffer: RTL and testbench

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_buffer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// ---------------------------------------------------------------------------
// uart_rx_buffer
//
// Circular receive FIFO between a UART receive stage and a transmit stage,
// plus a three-state issue FSM that hands one byte at a time to the
// transmitter and waits for its done strobe before offering the next one.
//
// Optional feature: define UART_RX_BUFFER_OVF_EN to enable the sticky
// overflow flag. Without it, ovf is tied to 0 and ovf_clr is ignored.
//
// Parameters
//   BYTE    data width in bits
//   DEPTH   FIFO entries, power of two, >= 2
//
// Ports
//   clk       in   single clock, rising edge
//   areset    in   asynchronous active-low reset
//   rx_valid  in   one-cycle strobe, byte present on rx_data
//   rx_data   in   received byte
//   tx_busy   in   transmit stage busy (only looked at in IDLE)
//   tx_done   in   one-cycle strobe, transmit stage finished a byte
//   tx_load   out  one-cycle strobe, tx_data has been loaded
//   tx_data   out  registered byte offered to the transmit stage
//   count     out  registered FIFO occupancy, 0..DEPTH
//   full      out  registered count == DEPTH
//   empty     out  registered count == 0
//   ovf       out  sticky overflow flag
//   ovf_clr   in   clears ovf
//
// Issue FSM
//   state | meaning
//   IDLE  | waiting for a byte in the FIFO and an idle transmitter
//   LOAD  | head byte just popped into tx_data, tx_load asserted (1 cycle)
//   WAIT  | byte handed over, waiting for tx_done
// ---------------------------------------------------------------------------
module uart_rx_buffer #(
  parameter int BYTE  = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     rx_valid,
  input  logic [BYTE-1:0]          rx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic                     tx_load,
  output logic [BYTE-1:0]          tx_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [BYTE-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count_nxt;
  logic            pop;
  logic            push_ok;
  logic            drop;

  // ---------------------------------------------------------------------
  // Issue FSM: next state and strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_load   = 1'b0;
    case (state)
      IDLE: begin
        // empty is registered, so a byte written this cycle cannot be
        // popped until the next one (no bypass path).
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        tx_load   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO push/pop qualification and occupancy
  // ---------------------------------------------------------------------
  // A push into a full FIFO still lands when the head is leaving in the
  // same cycle; otherwise the byte is dropped.
  assign push_ok = rx_valid && (!full || pop);
  assign drop    = rx_valid && full && !pop;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  // Storage is not reset; reset only clears the pointers, which is enough
  // to discard the contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= rx_data;
    end
  end

  // tx_data is only rewritten on a pop, so it holds from LOAD until the
  // next byte is issued.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      tx_data <= '0;
    end else if (pop) begin
      tx_data <= mem[rptr];
    end
  end

  // ---------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------
`ifdef UART_RX_BUFFER_OVF_EN
  // A drop wins over a simultaneous clear so no overflow event is lost.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf_clr | drop;
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

  localparam int BYTE  = 8;
  localparam int DEPTH = 8;
`ifdef UART_RX_BUFFER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       areset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_load;
  logic [7:0] tx_data;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       ovf_clr;

  uart_rx_buffer #(.BYTE(BYTE), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .areset   (areset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of stored bytes, phase of the issuer
  // (0 = idle, 1 = byte just loaded, 2 = waiting for done).
  logic [7:0] q[$];
  int         phase;
  logic [7:0] m_data;
  bit         m_ovf;
  logic [7:0] emitted[$];

  typedef struct {
    logic       rxv;
    logic [7:0] d;
    logic       busy;
    logic       done;
    logic [3:0] e_count;
    logic       e_load;
    logic [7:0] e_data;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    phase  = 0;
    m_data = 8'h00;
    m_ovf  = 1'b0;
  endtask

  // Advance the model by one cycle from the current inputs, clock the DUT,
  // then compare every output against the model.
  task automatic step();
    bit pop, full_m, push_ok, drop;
    full_m  = (q.size() == DEPTH);
    pop     = (phase == 0) && (q.size() > 0) && !tx_busy;
    push_ok = rx_valid && (!full_m || pop);
    drop    = rx_valid && full_m && !pop;
    if (pop) m_data = q.pop_front();
    if (push_ok) q.push_back(rx_data);
    case (phase)
      0: if (pop) phase = 1;
      1: phase = 2;
      default: if (tx_done) phase = 0;
    endcase
    if (OVF_EN) begin
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("count",   32'(count),   32'(q.size()));
    chk("full",    32'(full),    32'(q.size() == DEPTH));
    chk("empty",   32'(empty),   32'(q.size() == 0));
    chk("tx_load", 32'(tx_load), 32'(phase == 1));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("ovf",     32'(ovf),     32'(m_ovf));
    if (tx_load === 1'b1) emitted.push_back(tx_data);
  endtask

  task automatic idle_inputs();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  // Emit n bytes: wait (bounded) for each load, then return tx_done one
  // cycle into WAIT.
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      int w = 0;
      while (tx_load !== 1'b1 && w < 20) begin
        step();
        w++;
      end
      chk("drain_wait", 32'(tx_load), 32'd1);
      if (tx_load !== 1'b1) return;
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end
  endtask

  task automatic chk_emitted(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_len"}, 32'(emitted.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < emitted.size(); i++)
      chk(nm, 32'(emitted[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp_q[$];

    //          rxv  d      busy done cnt load data
    vt[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 8'hA5};
    vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 8'hA5};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 8'hA5};
    vt[4]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 4'd1, 1'b0, 8'hA5};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd1, 1'b0, 8'hA5};
    vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 8'h3C};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 8'h3C};
    vt[8]  = '{1'b1, 8'h77, 1'b0, 1'b0, 4'd1, 1'b0, 8'h3C};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b0, 8'h3C};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 8'h77};
    vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 8'h77};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 8'h77};
    vt[13] = '{1'b1, 8'h12, 1'b1, 1'b0, 4'd1, 1'b0, 8'h77};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 8'h12};
    vt[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 8'h12};
    vt[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 8'h12};

    idle_inputs();
    areset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_empty",   32'(empty),   32'd1);
    chk("rst_full",    32'(full),    32'd0);
    chk("rst_tx_load", 32'(tx_load), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_ovf",     32'(ovf),     32'd0);
    areset = 1'b1;

    // Single byte and latency / FSM sequencing table.
    repeat (9) step();
    foreach (vt[i]) begin
      rx_valid = vt[i].rxv;
      rx_data  = vt[i].d;
      tx_busy  = vt[i].busy;
      tx_done  = vt[i].done;
      step();
      chk($sformatf("vec%0d_count", i), 32'(count),   32'(vt[i].e_count));
      chk($sformatf("vec%0d_load", i),  32'(tx_load), 32'(vt[i].e_load));
      chk($sformatf("vec%0d_data", i),  32'(tx_data), 32'(vt[i].e_data));
    end
    idle_inputs();

    // Fill with the transmitter busy, then drain in order.
    tx_busy = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd8);
    tx_busy = 1'b0;
    emitted.delete();
    drain(8);
    exp_q.delete();
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
    chk_emitted("fill_order", exp_q);

    // Overflow while full, then simultaneous push/pop at full.
    tx_busy = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    push(8'hFF);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_set",   32'(ovf),   32'(OVF_EN));
    ovf_clr = 1'b1;
    push(8'hFF);
    chk("ovf_drop_and_clr", 32'(ovf), 32'(OVF_EN));
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);
    tx_busy = 1'b0;
    emitted.delete();
    push(8'h55);
    chk("simul_count", 32'(count),   32'd8);
    chk("simul_load",  32'(tx_load), 32'd1);
    drain(9);
    exp_q.push_back(8'h55);
    chk_emitted("simul_order", exp_q);

    // Streaming wrap: 20 bytes, tx_done 5 cycles after each tx_load.
    begin
      int idx = 0;
      int since = -100;
      int cyc = 0;
      int n_before;
      emitted.delete();
      while (emitted.size() < 20 && cyc < 2000) begin
        rx_valid = (idx < 20) && (q.size() < DEPTH);
        rx_data  = 8'(idx);
        tx_done  = (since == 5);
        n_before = emitted.size();
        step();
        if (rx_valid) idx++;
        if (since >= 0) since++;
        if (emitted.size() != n_before) since = 0;
        cyc++;
      end
      tx_done  = 1'b0;
      rx_valid = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
      chk_emitted("wrap_order", exp_q);
      chk("wrap_ovf", 32'(ovf), 32'd0);
      repeat (6) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end

    // Asynchronous reset while waiting for tx_done with three bytes queued.
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    tx_busy = 1'b0;
    step();
    step();
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_phase", 32'(phase), 32'd2);
    #2;
    areset = 1'b0;
    #1;
    chk("arst_count",   32'(count),   32'd0);
    chk("arst_empty",   32'(empty),   32'd1);
    chk("arst_full",    32'(full),    32'd0);
    chk("arst_tx_load", 32'(tx_load), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    chk("arst_ovf",     32'(ovf),     32'd0);
    model_reset();
    @(posedge clk);
    #3;
    areset = 1'b1;
    emitted.delete();
    repeat (10) step();
    chk("post_rst_no_load", 32'(emitted.size()), 32'd0);
    push(8'h9E);
    step();
    chk("post_rst_load", 32'(tx_load), 32'd1);
    chk("post_rst_data", 32'(tx_data), 32'h9E);
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rx_valid = ($urandom_range(0, 2) != 0);
      rx_data  = 8'($urandom);
      tx_busy  = ($urandom_range(0, 3) == 0);
      tx_done  = ($urandom_range(0, 2) == 0);
      ovf_clr  = ($urandom_range(0, 7) == 0);
      step();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
